// File: rtl/obstacle_scheduler.sv
// Obstacle spawn scheduler: gap-timed, collision-free release pulses to NSLOT obstacle slots.
// Optional SCHED_SPEEDUP_EN shortens the non-first gap by one tick per 8 spawns (floor MIN_GAP/2).

module obstacle_scheduler_slot (
    input  logic busy,
    input  logic lower_free,
    output logic grant,
    output logic free_out
);
    assign grant    = ~busy & ~lower_free;
    assign free_out = lower_free | ~busy;
endmodule

module obstacle_scheduler #(
    parameter int          NSLOT          = 3,
    parameter int          FIRST_GAP      = 96,
    parameter int          MIN_GAP        = 48,
    parameter int          GAP_RANGE_BITS = 5,
    parameter int          NUM_TYPES      = 6,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             moveTick,
    input  logic [1:0]       gameState,
    input  logic [NSLOT-1:0] slot_busy,
    output logic [NSLOT-1:0] spawn,
    output logic [3:0]       spawn_sel,
    output logic [7:0]       spawn_count,
    output logic             stall
);
    typedef enum logic [2:0] {IDLE, LOAD, COUNT, ARB, SPAWN} state_t;

    typedef struct packed {
        logic [NSLOT-1:0] spawn;
        logic [3:0]       sel;
        logic [7:0]       count;
        logic             stall;
    } sched_out_t;

    localparam logic [15:0] GAP_MASK = 16'((32'd1 << GAP_RANGE_BITS) - 32'd1);

    state_t      state_q, state_d;
    sched_out_t  out_q, out_d;
    logic [15:0] gap_q, gap_d;
    logic        first_q, first_d;
    logic [15:0] lfsr_q;
    logic        run;

    assign run = (gameState == 2'b10);

    // Galois LFSR runs every clock so gap/type draws depend on timing, not just spawn index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr_q <= LFSR_SEED;
        else      lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

    logic [NSLOT-1:0] grant;
    logic [NSLOT:0]   lower_free;
    logic             any_free;

    assign lower_free[0] = 1'b0;
    generate
        for (genvar i = 0; i < NSLOT; i++) begin : g_slot
            obstacle_scheduler_slot u_slot (
                .busy       (slot_busy[i]),
                .lower_free (lower_free[i]),
                .grant      (grant[i]),
                .free_out   (lower_free[i+1])
            );
        end
    endgenerate
    assign any_free = lower_free[NSLOT];

    logic [15:0] rand_gap, load_gap;
    assign rand_gap = 16'(MIN_GAP) + (lfsr_q & GAP_MASK);

`ifdef SCHED_SPEEDUP_EN
    logic [15:0] gap_cut, gap_floor;
    assign gap_cut   = {11'd0, out_q.count[7:3]};
    assign gap_floor = 16'(MIN_GAP / 2);
    assign load_gap  = (rand_gap >= gap_floor + gap_cut) ? rand_gap - gap_cut : gap_floor;
`else
    assign load_gap = rand_gap;
`endif

    // Fold 3 LFSR bits into 0..NUM_TYPES-1 with a single subtract.
    logic [3:0] type_raw, type_sel;
    assign type_raw = {1'b0, lfsr_q[2:0]};
    assign type_sel = (type_raw >= 4'(NUM_TYPES)) ? type_raw - 4'(NUM_TYPES) : type_raw;

    always_comb begin
        state_d       = state_q;
        gap_d         = gap_q;
        first_d       = first_q;
        out_d         = out_q;
        out_d.spawn   = '0;
        if (!run) begin
            state_d     = IDLE;
            out_d.stall = 1'b0;
            out_d.count = 8'd0;
            first_d     = 1'b1;
        end else begin
            case (state_q)
                IDLE:  state_d = LOAD;
                LOAD: begin
                    gap_d   = first_q ? 16'(FIRST_GAP) : load_gap;
                    first_d = 1'b0;
                    state_d = COUNT;
                end
                COUNT: begin
                    if (gap_q == 16'd0) begin
                        state_d = ARB;
                    end else if (moveTick) begin
                        gap_d = gap_q - 16'd1;
                        if (gap_q == 16'd1) state_d = ARB;
                    end
                end
                ARB: begin
                    if (any_free) begin
                        out_d.spawn = grant;
                        out_d.sel   = type_sel;
                        out_d.stall = 1'b0;
                        state_d     = SPAWN;
                    end else begin
                        out_d.stall = 1'b1;
                    end
                end
                SPAWN: begin
                    if (out_q.count != 8'hFF) out_d.count = out_q.count + 8'd1;
                    state_d = LOAD;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            out_q   <= '0;
            gap_q   <= 16'd0;
            first_q <= 1'b1;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            gap_q   <= gap_d;
            first_q <= first_d;
        end
    end

    assign spawn       = out_q.spawn;
    assign spawn_sel   = out_q.sel;
    assign spawn_count = out_q.count;
    assign stall       = out_q.stall;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed bench for obstacle_scheduler with a cycle-stepped behavioural model and per-cycle compare.
module tb_obstacle_scheduler;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       moveTick = 1'b0;
    logic [1:0] gameState = 2'b00;
    logic [2:0] slot_busy = 3'b000;
    logic [2:0] spawn;
    logic [3:0] spawn_sel;
    logic [7:0] spawn_count;
    logic       stall;

    always #5 clk = ~clk;

    obstacle_scheduler #(
        .NSLOT(3), .FIRST_GAP(96), .MIN_GAP(48), .GAP_RANGE_BITS(5),
        .NUM_TYPES(6), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst), .moveTick(moveTick), .gameState(gameState),
        .slot_busy(slot_busy), .spawn(spawn), .spawn_sel(spawn_sel),
        .spawn_count(spawn_count), .stall(stall)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_range(input string nm, input int val, input int lo, input int hi);
        n_cmp++;
        if (val < lo || val > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d..%0d (t=%0t)", nm, val, lo, hi, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] m_lfsr, m_cur;
    bit          m_in_game, m_load_due, m_hunting, m_first, m_stall;
    int          m_left, m_count, m_pick;
    logic [2:0]  m_pulse;
    logic [3:0]  m_sel;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_lfsr = 16'hACE1; m_in_game = 0; m_load_due = 0; m_hunting = 0;
            m_first = 1; m_left = 0; m_pulse = 3'b000; m_sel = 4'd0; m_count = 0; m_stall = 0;
        end else begin
            m_cur  = m_lfsr;
            m_lfsr = lfsr_next(m_lfsr);
            if (gameState != 2'b10) begin
                m_in_game = 0; m_pulse = 3'b000; m_stall = 0; m_count = 0;
                m_first = 1; m_hunting = 0; m_load_due = 0;
            end else if (!m_in_game) begin
                m_in_game = 1; m_load_due = 1;
            end else if (m_load_due) begin
                m_left = m_first ? 96 : 48 + int'(m_cur % 32);
                m_first = 0; m_load_due = 0; m_hunting = (m_left == 0);
            end else if (m_pulse != 3'b000) begin
                m_pulse = 3'b000;
                if (m_count < 255) m_count++;
                m_load_due = 1;
            end else if (m_hunting) begin
                m_pick = -1;
                for (int i = 0; i < 3; i++) if (!slot_busy[i] && m_pick < 0) m_pick = i;
                if (m_pick < 0) m_stall = 1;
                else begin
                    m_stall = 0; m_hunting = 0;
                    m_pulse = 3'(1 << m_pick);
                    m_sel   = 4'(int'(m_cur % 8) % 6);
                end
            end else if (moveTick) begin
                m_left--;
                if (m_left == 0) m_hunting = 1;
            end
        end
    end

    always @(negedge clk) begin
        check("spawn", 32'(spawn), 32'(m_pulse));
        check("spawn_sel", 32'(spawn_sel), 32'(m_sel));
        check("spawn_count", 32'(spawn_count), 32'(m_count));
        check("stall", 32'(stall), 32'(m_stall));
    end

    // ---------------- long-run monitor ----------------
    bit         mon_on = 0;
    int         cyc = 0, last_spawn = -1, e_spawns = 0;
    logic [2:0] prev_spawn = 3'b000;

    always @(negedge clk) begin
        cyc++;
        if (mon_on && spawn != 3'b000) begin
            check("onehot", 32'($countones(spawn)), 32'd1);
            check("width", 32'(prev_spawn), 32'd0);
            check_range("sel_range", int'(spawn_sel), 0, 5);
            if (last_spawn >= 0) check_range("gap_range", cyc - last_spawn - 3, 48, 79);
            last_spawn = cyc;
            e_spawns++;
        end
        prev_spawn = spawn;
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic first_gap(input string tag);
        int early = 0;
        for (int i = 0; i < 96; i++) begin
            moveTick = 1'b1;
            step();
            if (spawn != 3'b000) early++;
        end
        moveTick = 1'b0;
        check({tag, "_early"}, 32'(early), 32'd0);
        check({tag, "_arb"}, 32'(spawn), 32'd0);
        step();
        check({tag, "_pulse"}, 32'(spawn), 32'b001);
        step();
        check({tag, "_after"}, 32'(spawn), 32'd0);
    endtask

    task automatic tick_until_spawn(input string tag);
        int n = 0;
        moveTick = 1'b1;
        while (spawn == 3'b000 && n < 200) begin
            step();
            n++;
        end
        moveTick = 1'b0;
        check({tag, "_timeout"}, 32'(n < 200), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        check("rst_spawn", 32'(spawn), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_count", 32'(spawn_count), 32'd0);
        check("rst_sel", 32'(spawn_sel), 32'd0);

        // first spawn after exactly FIRST_GAP ticks
        rst = 1'b1; gameState = 2'b10;
        repeat (2) step();
        first_gap("B");
        check("B_count", 32'(spawn_count), 32'd1);

        // lowest free slot chosen, stall while all busy
        slot_busy = 3'b001;
        tick_until_spawn("C1");
        check("C_slot1", 32'(spawn), 32'b010);
        slot_busy = 3'b111;
        begin
            int n = 0;
            moveTick = 1'b1;
            while (!stall && n < 200) begin step(); n++; end
            moveTick = 1'b0;
            check("C_stall_timeout", 32'(n < 200), 32'd1);
        end
        repeat (5) step();
        check("C_stall", 32'(stall), 32'd1);
        check("C_nospawn", 32'(spawn), 32'd0);
        slot_busy = 3'b011;
        step();
        check("C_slot2", 32'(spawn), 32'b100);
        check("C_stall_clr", 32'(stall), 32'd0);
        slot_busy = 3'b000;
        step();
        check("C_count", 32'(spawn_count), 32'd3);

        // async reset mid-COUNT
        moveTick = 1'b1;
        repeat (10) step();
        moveTick = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("R_spawn", 32'(spawn), 32'd0);
        check("R_stall", 32'(stall), 32'd0);
        check("R_count", 32'(spawn_count), 32'd0);
        step();
        rst = 1'b1;
        repeat (2) step();
        first_gap("R");

        // leave RUN during COUNT, no spawns, FIRST_GAP again on return
        moveTick = 1'b1;
        repeat (10) step();
        gameState = 2'b11;
        begin
            int cnt = 0;
            for (int i = 0; i < 200; i++) begin
                step();
                if (spawn != 3'b000) cnt++;
            end
            check("D_nospawn", 32'(cnt), 32'd0);
        end
        moveTick = 1'b0;
        gameState = 2'b10;
        repeat (2) step();
        first_gap("D");

        // long run: ranges, one-hot, saturation
        gameState = 2'b00;
        repeat (3) step();
        mon_on = 1'b1;
        gameState = 2'b10;
        moveTick = 1'b1;
        begin
            int n = 0;
            while (e_spawns < 270 && n < 40000) begin step(); n++; end
            check("E_done", 32'(e_spawns >= 270), 32'd1);
        end
        moveTick = 1'b0;
        step();
        check("E_sat", 32'(spawn_count), 32'd255);
        mon_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/obstacle_scheduler.md
Name: obstacle_scheduler

Overview:
- Sequences the obstacle datapath: decides when the next obstacle enters the screen, which obstacle slot releases it, and which sprite type it uses.
- Replaces the free-running release pulse feeding each obstacle delegate with a gap-controlled, collision-free spawn schedule.
- Sits between the game FSM (gameState) and NSLOT obstacle delegates; consumes their in-range status and drives one-cycle release pulses plus a type select.

Parameters:
- NSLOT, 3, number of obstacle slots arbitrated (1..4)
- FIRST_GAP, 96, move ticks before the first spawn after entering RUN
- MIN_GAP, 48, minimum move ticks between spawns
- GAP_RANGE_BITS, 5, random gap extension width; gap = MIN_GAP + lfsr[GAP_RANGE_BITS-1:0] (0 allowed, meaning fixed gap)
- NUM_TYPES, 6, number of obstacle sprite types (4..8)
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- moveTick  in  1  one-clk pulse per obstacle move step, synchronous to clk
- gameState  in  2  2'b10 = RUN; any other value = not running
- slot_busy  in  NSLOT  slot i obstacle currently in range (on screen)
- spawn  out  NSLOT  one-hot, one-clk release pulse to slot i
- spawn_sel  out  4  sprite type for the most recent spawn (0..NUM_TYPES-1)
- spawn_count  out  8  saturating count of spawns since leaving IDLE
- stall  out  1  gap expired but every slot busy

Behaviour:
- Reset (rst=0, async): state IDLE, spawn=0, spawn_sel=0, spawn_count=0, stall=0, gap_cnt=0, lfsr=LFSR_SEED, first flag=1.
- LFSR: 16-bit Galois, mask 16'hB400, shift right; advances every clk out of reset regardless of state.
- States: IDLE, LOAD, COUNT, ARB, SPAWN.
- IDLE: all outputs except spawn_sel held/zeroed; first=1, spawn_count=0. gameState==2'b10 -> LOAD.
- LOAD (1 cycle): gap_cnt <= first ? FIRST_GAP : MIN_GAP + lfsr[GAP_RANGE_BITS-1:0]; first<=0; -> COUNT.
- COUNT: on moveTick, gap_cnt decrements; a moveTick with gap_cnt==1 sets gap_cnt=0 and moves to ARB. gap_cnt==0 on entry (possible only with parameter misuse) -> ARB immediately.
- ARB: select lowest-index i with slot_busy[i]==0. None free: stay in ARB, stall=1, no gap reload. Free found: stall=0, spawn[i]<=1, spawn_sel<=t where t=lfsr[2:0], t>=NUM_TYPES -> t-NUM_TYPES; -> SPAWN.
- SPAWN (1 cycle): spawn high exactly this cycle; spawn_count increments, saturates at 255; -> LOAD.
- Latency: moveTick expiring gap at cycle N -> ARB at N+1 -> spawn high at N+2 if a slot is free.
- spawn_sel is registered, changes only on the ARB->SPAWN transition, and is held otherwise (including in IDLE).
- gameState != 2'b10 in any non-IDLE state: next cycle IDLE, spawn=0, stall=0. An in-flight SPAWN pulse is truncated only if gameState drops in the ARB cycle; pulses are never longer than one cycle.
- slot_busy changing during ARB: decision uses the current-cycle value; no hold requirement on slot_busy.
- At most one spawn bit set ever; no spawn while not in RUN.

Optional Feature:
- Macro SCHED_SPEEDUP_EN.
- Defined: the LOAD non-first gap is reduced by spawn_count[7:3] (one tick per 8 spawns), floored at MIN_GAP/2.
- Undefined: gap is independent of spawn_count; spawn_count is still implemented.

Test Plan:
- Reset with rst=0 mid-COUNT, gameState=2'b10 -> spawn=0, stall=0, spawn_count=0 immediately (async); after release, first spawn occurs after exactly 96 moveTicks, 2 clk after the 96th tick.
- GAP_RANGE_BITS=0, MIN_GAP=48, all slots free -> spawns to slot 0 spaced exactly 48 moveTicks apart; spawn_count=1,2,3.
- slot_busy=3'b001 at gap expiry -> spawn=3'b010; slot_busy=3'b111 -> stall=1, no spawn; release slot_busy[2] -> spawn=3'b100 next cycle, stall=0.
- gameState 2'b10 -> 2'b11 during COUNT -> IDLE next clk, no spawn for 200 moveTicks; return to 2'b10 -> gap is FIRST_GAP again.
- LFSR_SEED=16'hACE1, 1000 spawns -> every spawn_sel < 6, every gap in [48, 79], spawn one-hot, one-clk wide, spawn_count saturates at 255.
- With SCHED_SPEEDUP_EN, GAP_RANGE_BITS=0 -> gap 48 for spawns 1-8, 47 for 9-16, never below 24.
